icmp_checksum_stream: RTL



---
 rtl/icmp_checksum_stream_if.sv | 38 +++
 rtl/icmp_checksum_stream.sv | 119 +++++++++++
 2 files changed

// File: rtl/icmp_checksum_stream_if.sv
// Stream-in / result-out handshake bundle for icmp_checksum_stream.
// in_keep exists only when ICMP_CSUM_BYTE_MASK_EN is defined.
interface icmp_checksum_stream_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
`ifdef ICMP_CSUM_BYTE_MASK_EN
  logic [DATA_W/8-1:0] in_keep;
`endif
  logic              csum_valid;
  logic              csum_ready;
  logic [15:0]       csum;
  logic              csum_ok;
  logic              csum_err;

`ifdef ICMP_CSUM_BYTE_MASK_EN
  modport master (
    output in_valid, in_data, in_last, in_keep, csum_ready,
    input  in_ready, csum_valid, csum, csum_ok, csum_err
  );
  modport slave (
    input  in_valid, in_data, in_last, in_keep, csum_ready,
    output in_ready, csum_valid, csum, csum_ok, csum_err
  );
`else
  modport master (
    output in_valid, in_data, in_last, csum_ready,
    input  in_ready, csum_valid, csum, csum_ok, csum_err
  );
  modport slave (
    input  in_valid, in_data, in_last, csum_ready,
    output in_ready, csum_valid, csum, csum_ok, csum_err
  );
`endif
endinterface

// File: rtl/icmp_checksum_stream.sv
// Streaming one's-complement (Internet) checksum over DATA_W-bit beats, up to MAX_BEATS per packet.
// Optional byte masking of each beat via in_keep when ICMP_CSUM_BYTE_MASK_EN is defined.
module icmp_checksum_stream #(
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 64
) (
  input  logic                    clock,
  input  logic                    hardreset_n,
  icmp_checksum_stream_if.slave   bus
);

  localparam int LANES = DATA_W / 16;
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {ACC, FOLD1, FOLD2, OUT} state_t;

  state_t             state_q, state_d;
  logic [31:0]        acc_q, acc_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               err_q, err_d;
  logic [15:0]        csum_q, csum_d;
  logic               csum_ok_q, csum_ok_d;
  logic               csum_err_q, csum_err_d;

  logic [DATA_W-1:0]  data_m;
  logic [31:0]        beat_sum;
  logic [31:0]        acc_fold;
  logic               beat_full;
  logic               in_ready;
  logic               csum_valid;

  always_comb begin
    data_m = bus.in_data;
`ifdef ICMP_CSUM_BYTE_MASK_EN
    for (int unsigned b = 0; b < DATA_W / 8; b++) begin
      if (!bus.in_keep[b]) data_m[b*8 +: 8] = '0;
    end
`endif
    beat_sum = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      beat_sum = beat_sum + {16'h0000, data_m[l*16 +: 16]};
    end
  end

  assign acc_fold  = {16'h0000, acc_q[15:0]} + {16'h0000, acc_q[31:16]};
  assign beat_full = (beat_cnt_q == CNT_W'(MAX_BEATS - 1));

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    csum_d     = csum_q;
    csum_ok_d  = csum_ok_q;
    csum_err_d = csum_err_q;
    in_ready   = 1'b0;
    csum_valid = 1'b0;
    unique case (state_q)
      ACC: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          acc_d      = acc_q + beat_sum;
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (bus.in_last || beat_full) state_d = FOLD1;
          // Hitting the beat limit without in_last marks the packet as truncated.
          if (beat_full && !bus.in_last) err_d = 1'b1;
        end
      end
      FOLD1: begin
        acc_d   = acc_fold;
        state_d = FOLD2;
      end
      FOLD2: begin
        acc_d      = acc_fold;
        csum_d     = ~acc_fold[15:0];
        csum_ok_d  = (acc_fold[15:0] == 16'hFFFF);
        csum_err_d = err_q;
        state_d    = OUT;
      end
      OUT: begin
        csum_valid = 1'b1;
        if (bus.csum_ready) begin
          acc_d      = '0;
          beat_cnt_d = '0;
          err_d      = 1'b0;
          state_d    = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clock or negedge hardreset_n) begin
    if (!hardreset_n) begin
      state_q    <= ACC;
      acc_q      <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
      csum_q     <= '0;
      csum_ok_q  <= 1'b0;
      csum_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
      csum_q     <= csum_d;
      csum_ok_q  <= csum_ok_d;
      csum_err_q <= csum_err_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.csum_valid = csum_valid;
  assign bus.csum       = csum_q;
  assign bus.csum_ok    = csum_ok_q;
  assign bus.csum_err   = csum_err_q;

endmodule
